// File: rtl/jk_seq_pkg.sv
// Shared types for the JK register sequencer: opcodes, FSM states, default width.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package jk_seq_pkg;

    localparam int JK_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    // Map an opcode and one mask bit to the {J,K} pair for that register bit.
    function automatic logic [1:0] jk_code(input op_t op, input logic sel);
        logic [1:0] jk;
        jk = 2'b00;
        if (sel) begin
            case (op)
                OP_RESET:  jk = 2'b01;
                OP_SET:    jk = 2'b10;
                OP_TOGGLE: jk = 2'b11;
                default:   jk = 2'b00;
            endcase
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop bit with asynchronous active-low clear.
// Latency: Q reflects J/K one CLK edge later; clear is immediate.
// Backpressure: none, updates every edge.
module jk_cell (
    input  logic CLK,
    input  logic CLR,
    input  logic J,
    input  logic K,
    output logic Q
);

    // Classic JK behaviour; J=K=1 inverts the stored bit, never X.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   Q <= 1'b0;
                2'b10:   Q <= 1'b1;
                2'b11:   Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_reg_sequencer.sv
// Two-requester round-robin sequencer applying masked JK ops to a register; optional done counter under JK_SEQ_CNT_EN.
// Latency: done pulses two cycles after the accept cycle; one command per three cycles at best.
// Backpressure: reqN_ready is only raised in IDLE for the granted requester; others wait with valid held.
module jk_reg_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = JK_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_mask,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_mask,
    output logic             req1_ready,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] q
`ifdef JK_SEQ_CNT_EN
    ,
    output logic [7:0]       cmd_cnt
`endif
);

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] mask_q;
    logic             id_q;
    logic             last_q;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    // Round-robin grant in IDLE only; on conflict the requester not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (CLR && state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Command FSM: latch the granted command, apply it for one cycle, then report.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state  <= ST_IDLE;
            op_q   <= OP_HOLD;
            mask_q <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_q   <= gnt1 ? op_t'(req1_op) : op_t'(req0_op);
                        mask_q <= gnt1 ? req1_mask : req0_mask;
                        id_q   <= gnt1;
                        last_q <= gnt1;
                        state  <= ST_APPLY;
                    end
                end
                ST_APPLY: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // J/K are only driven during APPLY so the register moves on the edge that ends it.
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (state == ST_APPLY) begin
            for (int i = 0; i < WIDTH; i++) begin
                {j_vec[i], k_vec[i]} = jk_code(op_q, mask_q[i]);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
        jk_cell u_cell (
            .CLK (CLK),
            .CLR (CLR),
            .J   (j_vec[i]),
            .K   (k_vec[i]),
            .Q   (q[i])
        );
    end

    // Response outputs decode straight from the state flop, so they are glitch-free.
    assign done    = (state == ST_RESP);
    assign done_id = done & id_q;
    assign rdata   = done ? q : '0;

`ifdef JK_SEQ_CNT_EN
    // Saturating count of completed commands.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cmd_cnt <= 8'd0;
        end else if (done && cmd_cnt != 8'hFF) begin
            cmd_cnt <= cmd_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jk_reg_sequencer.sv
// Scoreboard bench for jk_reg_sequencer: directed commands, decoupled done monitor.
// Latency: checks done two cycles after accept and three-cycle spacing under contention.
// Backpressure: stimulus holds valid until the matching ready is seen.
module tb_jk_reg_sequencer;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       req0_valid = 1'b0;
    logic [1:0] req0_op = 2'b00;
    logic [3:0] req0_mask = 4'h0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [1:0] req1_op = 2'b00;
    logic [3:0] req1_mask = 4'h0;
    logic       req1_ready;
    logic       done;
    logic       done_id;
    logic [3:0] rdata;
    logic [3:0] q;
`ifdef JK_SEQ_CNT_EN
    logic [7:0] cmd_cnt;
`endif

    jk_reg_sequencer #(.WIDTH(4)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_mask  (req0_mask),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_mask  (req1_mask),
        .req1_ready (req1_ready),
        .done       (done),
        .done_id    (done_id),
        .rdata      (rdata),
        .q          (q)
`ifdef JK_SEQ_CNT_EN
        ,
        .cmd_cnt    (cmd_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       id;
        logic [3:0] rd;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   spc_on = 1'b0;
    int   spc_prev = -1;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: samples mid-low-phase, records accepts and checks every done.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge CLK);
            #2;
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
                acc_q.push_back(cyc);
            if (CLR && done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 with rdata %0h expected no done (cycle %0d)", rdata, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("rdata", rdata, e.rd);
                    if (acc_q.size() > 0) begin
                        a = acc_q.pop_front();
                        chk("latency", cyc - a, 2);
                    end else begin
                        total++;
                        bad++;
                        $display("FAIL latency: done without recorded accept expected an accept (cycle %0d)", cyc);
                    end
                    if (spc_on) begin
                        if (spc_prev >= 0) chk("done_spacing", cyc - spc_prev, 3);
                        spc_prev = cyc;
                    end
                end
            end else if (CLR) begin
                chk("rdata_idle_zero", rdata, 0);
            end
        end
    end

    task automatic issue(input bit id, input logic [1:0] op, input logic [3:0] m,
                         input logic [3:0] er, input bit push);
        int   n;
        exp_t e;
        @(negedge CLK);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_mask = m;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_mask = m;
        end
        if (push) begin
            e.id = id;
            e.rd = er;
            sb.push_back(e);
        end
        n = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 40) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: requester %0d never got ready expected ready within 40 cycles", id);
        end
        @(posedge CLK);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        // Garbage on the request inputs must not disturb the latched command.
        req0_op = 2'b11; req0_mask = 4'hF;
        req1_op = 2'b11; req1_mask = 4'hF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d responses pending expected 0", sb.size());
        end
        @(negedge CLK);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   t;

        // Reset state, with both valids high to prove readies stay low.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #12;
        chk("rst_q", q, 4'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_done_id", done_id, 1'b0);
        chk("rst_rdata", rdata, 4'h0);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;

        // req0 SET 0101, then req1 TOGGLE all.
        issue(1'b0, 2'b10, 4'b0101, 4'b0101, 1'b1);
        drain();
        chk("q_after_set", q, 4'b0101);
        issue(1'b1, 2'b11, 4'b1111, 4'b1010, 1'b1);
        drain();
        chk("q_after_toggle", q, 4'b1010);

        // Contention: both valid with HOLD, grants alternate starting with 0.
        @(negedge CLK);
        req0_valid = 1'b1; req0_op = 2'b00; req0_mask = 4'hF;
        req1_valid = 1'b1; req1_op = 2'b00; req1_mask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            e.id = i[0];
            e.rd = 4'b1010;
            sb.push_back(e);
        end
        spc_on = 1'b1;
        spc_prev = -1;
        n = 0;
        t = 0;
        #1;
        while (n < 4 && t < 60) begin
            if (req0_ready || req1_ready) n++;
            if (n < 4) begin
                @(negedge CLK);
                #1;
            end
            t++;
        end
        if (n < 4) begin
            total++;
            bad++;
            $display("FAIL rr_accept_timeout: got %0d accepts expected 4", n);
        end
        @(posedge CLK);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        spc_on = 1'b0;

        // From all-ones: RESET low pair, then HOLD returns unchanged value.
        issue(1'b0, 2'b10, 4'b1111, 4'b1111, 1'b1);
        issue(1'b1, 2'b01, 4'b0011, 4'b1100, 1'b1);
        issue(1'b0, 2'b00, 4'b1111, 4'b1100, 1'b1);
        drain();
        chk("q_after_hold", q, 4'b1100);

        // Reset in APPLY: command discarded, q cleared at once, no done.
        issue(1'b0, 2'b10, 4'b0001, 4'h0, 1'b0);
        #2;
        CLR = 1'b0;
        #1;
        chk("midrst_q", q, 4'h0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_rdata", rdata, 4'h0);
        @(negedge CLK);
        acc_q.delete();
        CLR = 1'b1;
        repeat (4) @(negedge CLK);
        chk("post_rst_q_hold", q, 4'h0);
        issue(1'b1, 2'b11, 4'b0011, 4'b0011, 1'b1);
        drain();
        chk("q_after_recover", q, 4'b0011);

`ifdef JK_SEQ_CNT_EN
        chk("cnt_one", cmd_cnt, 8'd1);
        for (int i = 0; i < 260; i++) begin
            issue(i[0], 2'b00, 4'hF, 4'b0011, 1'b1);
        end
        drain();
        chk("cnt_sat", cmd_cnt, 8'd255);
        @(negedge CLK);
        CLR = 1'b0;
        #1;
        chk("cnt_rst", cmd_cnt, 8'd0);
        @(negedge CLK);
        CLR = 1'b1;
`endif

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_reg_sequencer.md
JK_REG_SEQUENCER -- requirements
Module: jk_reg_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, number of JK register bits.
REQ-002 The block SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port CLR, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req0_valid, input, 1, requester 0 command valid.
REQ-005 The block SHALL have port req0_op, input, 2, requester 0 opcode: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
REQ-006 The block SHALL have port req0_mask, input, WIDTH, requester 0 bit-select mask.
REQ-007 The block SHALL have port req0_ready, output, 1, requester 0 command accepted this cycle.
REQ-008 The block SHALL have ports req1_valid, req1_op, req1_mask and req1_ready, identical to REQ-004..007, for requester 1.
REQ-009 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have port done_id, output, 1, index of the requester that owns the completing command.
REQ-011 The block SHALL have port rdata, output, WIDTH, register value after the command, valid while done=1.
REQ-012 The block SHALL have port q, output, WIDTH, live register contents.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY and RESP; transitions are IDLE->APPLY on accept, APPLY->RESP always, and RESP->IDLE always.
REQ-014 In IDLE the arbiter SHALL select one valid requester and assert only its reqN_ready, combinationally from valid; acceptance = valid && ready.
REQ-015 Arbitration SHALL be round-robin: on a conflict, grant the requester not served last; the last-served pointer resets to 1 so requester 0 wins the first conflict.
REQ-016 On accept, op, mask and requester id SHALL be latched; later changes to request inputs SHALL NOT affect the command in flight.
REQ-017 A requester SHALL hold valid, op and mask stable until ready; the block SHALL NOT assert ready outside IDLE.
REQ-018 In APPLY, each bit i SHALL drive J/K: mask[i]=0 or HOLD gives J=0,K=0; RESET gives J=0,K=1; SET gives J=1,K=0; TOGGLE gives J=1,K=1.
REQ-019 J=K=1 SHALL toggle the bit; it SHALL never produce an unknown value.
REQ-020 The register SHALL update at the rising edge ending APPLY.
REQ-021 In RESP, done=1, done_id = latched id, and rdata = q.
REQ-022 Latency SHALL be: done asserts two cycles after the accept edge; throughput is at most one command per 3 cycles.
REQ-023 Outside RESP, done=0 and rdata=0.
REQ-024 If both valids are low in IDLE, the FSM SHALL stay in IDLE and the register SHALL hold.

Reset
REQ-025 CLR low SHALL immediately force state=IDLE, q=0, done=0, done_id=0, rdata=0, both readies low, and last-served pointer=1.
REQ-026 Reset during APPLY or RESP SHALL discard the in-flight command with no done pulse; normal operation resumes on the first CLK edge after CLR rises.

Configuration
REQ-027 With macro JK_SEQ_CNT_EN defined, the block SHALL add output cmd_cnt[7:0], which counts done pulses, saturates at 255, and resets to 0.
REQ-028 Without JK_SEQ_CNT_EN, port cmd_cnt and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-029 Shared package jk_seq_pkg SHALL hold the opcode enum, the FSM state enum and the WIDTH default constant.
REQ-030 Each register bit SHALL be an instance of sub-module jk_cell (inputs CLK, CLR, J, K; output Q) with async active-low clear and a defined toggle on J=K=1.

Verification
REQ-031 Bench SHALL cover: after reset, req0 SET mask=4'b0101 -> done 2 cycles after accept, done_id=0, rdata=4'b0101.
REQ-032 Bench SHALL cover: from q=4'b0101, req1 TOGGLE mask=4'b1111 -> rdata=4'b1010, done_id=1.
REQ-033 Bench SHALL cover: both valid continuously with HOLD ops -> grants alternate 0,1,0,1, each done spaced 3 cycles apart.
REQ-034 Bench SHALL cover: from q=4'b1111, RESET mask=4'b0011 -> rdata=4'b1100; a HOLD command then returns 4'b1100 unchanged.
REQ-035 Bench SHALL cover: CLR pulsed low during APPLY -> q=0 immediately, no done pulse, the next command completes normally.
REQ-036 Bench SHALL cover, with JK_SEQ_CNT_EN: 260 commands -> cmd_cnt=255; it reads 0 after reset.
